// File: rtl/psr_pkg.sv
// rtl/psr_pkg.sv - PSR field positions, flag index and event-priority encoding
package psr_pkg;

  localparam int PSR_ICC_HI   = 23;
  localparam int PSR_ICC_LO   = 20;
  localparam int PSR_PIL_HI   = 11;
  localparam int PSR_PIL_LO   = 8;
  localparam int PSR_S        = 7;
  localparam int PSR_PS       = 6;
  localparam int PSR_ET       = 5;
  localparam int PSR_CWP_HI   = 4;
  localparam int PSR_CWP_LO   = 0;

  localparam int CC_CARRY_IDX = 2;

  // Winning event of a cycle after priority resolution
  typedef enum logic [2:0] {
    EV_NONE,
    EV_TRAP,
    EV_RETT,
    EV_WR_PSR,
    EV_SAVE,
    EV_RESTORE,
    EV_SAVE_RESTORE
  } psr_event_e;

endpackage

// File: rtl/psr_window_register_if.sv
// rtl/psr_window_register_if.sv - control-unit bus of the PSR block
interface psr_window_register_if #(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = $clog2(NWINDOWS)
);
  logic [3:0]          cc_in;
  logic                cc_we;
  logic                save;
  logic                restore;
  logic                trap;
  logic                rett;
  logic                wr_psr;
  logic [31:0]         psr_wdata;
  logic                wr_wim;
  logic [NWINDOWS-1:0] wim_wdata;

  logic [3:0]          icc;
  logic                carry;
  logic [CWP_W-1:0]    cwp;
  logic                s;
  logic                ps;
  logic                et;
  logic [NWINDOWS-1:0] wim;
  logic [3:0]          pil;
  logic [31:0]         psr_rdata;
  logic                window_overflow;
  logic                window_underflow;
  logic                illegal_op;
  logic                error_mode;

  modport master (
    output cc_in, cc_we, save, restore, trap, rett, wr_psr, psr_wdata, wr_wim, wim_wdata,
    input  icc, carry, cwp, s, ps, et, wim, pil, psr_rdata,
           window_overflow, window_underflow, illegal_op, error_mode
  );

  modport slave (
    input  cc_in, cc_we, save, restore, trap, rett, wr_psr, psr_wdata, wr_wim, wim_wdata,
    output icc, carry, cwp, s, ps, et, wim, pil, psr_rdata,
           window_overflow, window_underflow, illegal_op, error_mode
  );
endinterface

// File: rtl/cwp_wrap.sv
// rtl/cwp_wrap.sv - combinational modulo-NWINDOWS increment or decrement of a CWP
module cwp_wrap #(
  parameter int NWINDOWS = 8,
  parameter bit INC      = 1'b1
) (
  input  logic [$clog2(NWINDOWS)-1:0] cwp,
  output logic [$clog2(NWINDOWS)-1:0] cwp_next
);
  localparam int CWP_W = $clog2(NWINDOWS);
  localparam logic [CWP_W-1:0] LAST = CWP_W'(NWINDOWS - 1);

  // Wrap at NWINDOWS-1 rather than at the power of two
  always_comb begin
    if (INC) cwp_next = (cwp == LAST) ? '0 : cwp + CWP_W'(1);
    else     cwp_next = (cwp == '0) ? LAST : cwp - CWP_W'(1);
  end
endmodule

// File: rtl/psr_window_register.sv
// rtl/psr_window_register.sv - SPARC-style PSR with window rotation and trap handling; option PSR_PIL_EN
module psr_window_register
  import psr_pkg::*;
#(
  parameter int NWINDOWS  = 8,
  parameter int CWP_RESET = 0
) (
  input  logic                  clk,
  input  logic                  Clr,
  psr_window_register_if.slave  bus
);
  localparam int CWP_W = $clog2(NWINDOWS);

  logic [3:0]          icc_q, icc_d;
  logic [CWP_W-1:0]    cwp_q, cwp_d;
  logic                s_q, s_d, ps_q, ps_d, et_q, et_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic [3:0]          pil_q, pil_d;
  logic                of_q, of_d, uf_q, uf_d, ill_q, ill_d, err_q, err_d;
  logic [CWP_W-1:0]    cwp_inc, cwp_dec;
  logic                psr_cwp_ok;
  psr_event_e          ev;
  logic                unused_wdata;

  cwp_wrap #(.NWINDOWS(NWINDOWS), .INC(1'b1)) u_inc (.cwp(cwp_q), .cwp_next(cwp_inc));
  cwp_wrap #(.NWINDOWS(NWINDOWS), .INC(1'b0)) u_dec (.cwp(cwp_q), .cwp_next(cwp_dec));

  assign psr_cwp_ok = {27'd0, bus.psr_wdata[PSR_CWP_HI:PSR_CWP_LO]} < 32'(NWINDOWS);

`ifdef PSR_PIL_EN
  assign unused_wdata = ^{bus.psr_wdata[31:24], bus.psr_wdata[19:12]};
`else
  assign unused_wdata = ^{bus.psr_wdata[31:24], bus.psr_wdata[19:8]};
`endif

  // Resolve simultaneous requests to the single winning event
  always_comb begin
    ev = EV_NONE;
    if (bus.trap)                     ev = EV_TRAP;
    else if (bus.rett)                ev = EV_RETT;
    else if (bus.wr_psr)              ev = EV_WR_PSR;
    else if (bus.save && bus.restore) ev = EV_SAVE_RESTORE;
    else if (bus.save)                ev = EV_SAVE;
    else if (bus.restore)             ev = EV_RESTORE;
  end

  // Next-state of every PSR field; WIM checks always see the pre-write mask
  always_comb begin
    icc_d = icc_q;
    cwp_d = cwp_q;
    s_d   = s_q;
    ps_d  = ps_q;
    et_d  = et_q;
    pil_d = pil_q;
    wim_d = bus.wr_wim ? bus.wim_wdata : wim_q;
    of_d  = 1'b0;
    uf_d  = 1'b0;
    ill_d = 1'b0;
    err_d = err_q;
    unique case (ev)
      EV_TRAP: begin
        if (et_q) begin
          cwp_d = cwp_dec;
          ps_d  = s_q;
          s_d   = 1'b1;
          et_d  = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      EV_RETT: begin
        if (et_q) begin
          ill_d = 1'b1;
        end else if (wim_q[cwp_inc]) begin
          uf_d = 1'b1;
        end else begin
          cwp_d = cwp_inc;
          s_d   = ps_q;
          et_d  = 1'b1;
        end
      end
      EV_WR_PSR: begin
        if (psr_cwp_ok) begin
          icc_d = bus.psr_wdata[PSR_ICC_HI:PSR_ICC_LO];
          s_d   = bus.psr_wdata[PSR_S];
          ps_d  = bus.psr_wdata[PSR_PS];
          et_d  = bus.psr_wdata[PSR_ET];
          cwp_d = bus.psr_wdata[CWP_W-1:0];
`ifdef PSR_PIL_EN
          pil_d = bus.psr_wdata[PSR_PIL_HI:PSR_PIL_LO];
`endif
        end else begin
          ill_d = 1'b1;
        end
      end
      EV_SAVE_RESTORE: ill_d = 1'b1;
      EV_SAVE: begin
        if (wim_q[cwp_dec]) of_d  = 1'b1;
        else                cwp_d = cwp_dec;
      end
      EV_RESTORE: begin
        if (wim_q[cwp_inc]) uf_d  = 1'b1;
        else                cwp_d = cwp_inc;
      end
      default: ;
    endcase
    // Flag writes survive window rotation but lose to trap/rett/wr_psr
    if (bus.cc_we && (ev inside {EV_NONE, EV_SAVE, EV_RESTORE, EV_SAVE_RESTORE}))
      icc_d = bus.cc_in;
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      icc_q <= '0;
      cwp_q <= CWP_W'(CWP_RESET);
      s_q   <= 1'b1;
      ps_q  <= 1'b0;
      et_q  <= 1'b0;
      wim_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
      ill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      icc_q <= icc_d;
      cwp_q <= cwp_d;
      s_q   <= s_d;
      ps_q  <= ps_d;
      et_q  <= et_d;
      wim_q <= wim_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
      ill_q <= ill_d;
      err_q <= err_d;
    end
  end

`ifdef PSR_PIL_EN
  // Interrupt level register, present only with the option enabled
  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) pil_q <= '0;
    else     pil_q <= pil_d;
  end
`else
  assign pil_q = 4'd0;
`endif

  // Packed PSR view straight from the registers
  always_comb begin
    bus.psr_rdata                        = '0;
    bus.psr_rdata[PSR_ICC_HI:PSR_ICC_LO] = icc_q;
    bus.psr_rdata[PSR_PIL_HI:PSR_PIL_LO] = pil_q;
    bus.psr_rdata[PSR_S]                 = s_q;
    bus.psr_rdata[PSR_PS]                = ps_q;
    bus.psr_rdata[PSR_ET]                = et_q;
    bus.psr_rdata[PSR_CWP_HI:PSR_CWP_LO] = 5'(cwp_q);
  end

  assign bus.icc              = icc_q;
  assign bus.carry            = icc_q[CC_CARRY_IDX];
  assign bus.cwp              = cwp_q;
  assign bus.s                = s_q;
  assign bus.ps               = ps_q;
  assign bus.et               = et_q;
  assign bus.wim              = wim_q;
  assign bus.pil              = pil_q;
  assign bus.window_overflow  = of_q;
  assign bus.window_underflow = uf_q;
  assign bus.illegal_op       = ill_q;
  assign bus.error_mode       = err_q;
endmodule

// File: tb/tb_psr_window_register.sv
// tb/tb_psr_window_register.sv - scoreboard bench for psr_window_register (NWINDOWS=8)
module tb_psr_window_register;

  typedef struct packed {
    logic [3:0]  icc;
    logic        carry;
    logic [2:0]  cwp;
    logic        s;
    logic        ps;
    logic        et;
    logic [7:0]  wim;
    logic [3:0]  pil;
    logic        of;
    logic        uf;
    logic        ill;
    logic        err;
    logic [31:0] rdata;
  } obs_t;

`ifdef PSR_PIL_EN
  localparam logic [3:0] PIL_A = 4'hA;
`else
  localparam logic [3:0] PIL_A = 4'h0;
`endif

  logic clk;
  logic Clr;
  int   checks;
  int   failures;
  obs_t  exp_q[$];
  string name_q[$];

  psr_window_register_if #(.NWINDOWS(8)) bus ();

  psr_window_register #(.NWINDOWS(8), .CWP_RESET(0)) dut (
    .clk (clk),
    .Clr (Clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic [3:0] icc, input logic [2:0] cwp, input logic s,
                              input logic ps, input logic et, input logic [7:0] wim,
                              input logic [3:0] pil, input logic of, input logic uf,
                              input logic ill, input logic err);
    obs_t o;
    o.icc   = icc;
    o.carry = icc[2];
    o.cwp   = cwp;
    o.s     = s;
    o.ps    = ps;
    o.et    = et;
    o.wim   = wim;
    o.pil   = pil;
    o.of    = of;
    o.uf    = uf;
    o.ill   = ill;
    o.err   = err;
    o.rdata = {8'h00, icc, 8'h00, pil, s, ps, et, 2'b00, cwp};
    return o;
  endfunction

  task automatic push(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle_inputs();
    bus.cc_in = '0; bus.cc_we = 0; bus.save = 0; bus.restore = 0; bus.trap = 0;
    bus.rett = 0; bus.wr_psr = 0; bus.psr_wdata = '0; bus.wr_wim = 0; bus.wim_wdata = '0;
  endtask

  // One request cycle: drive at negedge, capture expectation just after the edge
  task automatic step(input string nm, input logic sv, input logic rs, input logic tr,
                      input logic rt, input logic wp, input logic [31:0] wd,
                      input logic ww, input logic [7:0] wimd, input logic ccwe,
                      input logic [3:0] cc, input obs_t e);
    bus.save = sv; bus.restore = rs; bus.trap = tr; bus.rett = rt;
    bus.wr_psr = wp; bus.psr_wdata = wd; bus.wr_wim = ww; bus.wim_wdata = wimd;
    bus.cc_we = ccwe; bus.cc_in = cc;
    @(posedge clk);
    #1;
    idle_inputs();
    push(nm, e);
    @(negedge clk);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs on the falling edge
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.icc = bus.icc; a.carry = bus.carry; a.cwp = bus.cwp; a.s = bus.s; a.ps = bus.ps;
      a.et = bus.et; a.wim = bus.wim; a.pil = bus.pil; a.of = bus.window_overflow;
      a.uf = bus.window_underflow; a.ill = bus.illegal_op; a.err = bus.error_mode;
      a.rdata = bus.psr_rdata;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got icc=%h c=%b cwp=%0d s=%b ps=%b et=%b wim=%h pil=%h of=%b uf=%b ill=%b err=%b rd=%h ; want icc=%h c=%b cwp=%0d s=%b ps=%b et=%b wim=%h pil=%h of=%b uf=%b ill=%b err=%b rd=%h",
                 nm, a.icc, a.carry, a.cwp, a.s, a.ps, a.et, a.wim, a.pil, a.of, a.uf, a.ill, a.err, a.rdata,
                 e.icc, e.carry, e.cwp, e.s, e.ps, e.et, e.wim, e.pil, e.of, e.uf, e.ill, e.err, e.rdata);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    bus.save = 1'b1;
    bus.trap = 1'b1;
    Clr = 1'b1;
    #1;
    push("reset", mk(4'h0, 3'd0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0));
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    Clr = 1'b0;
    @(negedge clk);

    //        name            sv rs tr rt wp wdata         ww wimd   cc cc_in  expected
    step("save_wrap",         1, 0, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h0, 3'd7, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0));
    step("restore_wrap",      0, 1, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h0, 3'd0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0));
    step("wr_psr_cwp3",       0, 0, 0, 0, 1, 32'h00A00A83, 0, 8'h00, 0, 4'h0, mk(4'hA, 3'd3, 1, 0, 0, 8'h00, PIL_A, 0, 0, 0, 0));
    step("wr_wim",            0, 0, 0, 0, 0, 32'h0,        1, 8'h04, 0, 4'h0, mk(4'hA, 3'd3, 1, 0, 0, 8'h04, PIL_A, 0, 0, 0, 0));
    step("save_overflow",     1, 0, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'hA, 3'd3, 1, 0, 0, 8'h04, PIL_A, 1, 0, 0, 0));
    step("overflow_cleared",  0, 0, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'hA, 3'd3, 1, 0, 0, 8'h04, PIL_A, 0, 0, 0, 0));
    step("wr_psr_et1_cwp5",   0, 0, 0, 0, 1, 32'h00000065, 0, 8'h00, 0, 4'h0, mk(4'h0, 3'd5, 0, 1, 1, 8'h04, 4'h0, 0, 0, 0, 0));
    step("trap_et1",          0, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h0, 3'd4, 1, 0, 0, 8'h04, 4'h0, 0, 0, 0, 0));
    step("rett_et0",          0, 0, 0, 1, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h0, 3'd5, 0, 0, 1, 8'h04, 4'h0, 0, 0, 0, 0));
    step("rett_et1_illegal",  0, 0, 0, 1, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h0, 3'd5, 0, 0, 1, 8'h04, 4'h0, 0, 0, 1, 0));
    step("save_restore_cc",   1, 1, 0, 0, 0, 32'h0,        0, 8'h00, 1, 4'h4, mk(4'h4, 3'd5, 0, 0, 1, 8'h04, 4'h0, 0, 0, 1, 0));
    step("illegal_cleared",   0, 0, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h4, 3'd5, 0, 0, 1, 8'h04, 4'h0, 0, 0, 0, 0));
    step("wr_psr_cwp9_drop",  0, 0, 0, 0, 1, 32'h00F00089, 0, 8'h00, 0, 4'h0, mk(4'h4, 3'd5, 0, 0, 1, 8'h04, 4'h0, 0, 0, 1, 0));
    step("cc_we_only",        0, 0, 0, 0, 0, 32'h0,        0, 8'h00, 1, 4'h3, mk(4'h3, 3'd5, 0, 0, 1, 8'h04, 4'h0, 0, 0, 0, 0));
    step("wr_psr_beats_save", 1, 0, 0, 0, 1, 32'h008000A1, 0, 8'h00, 1, 4'hF, mk(4'h8, 3'd1, 1, 0, 1, 8'h04, 4'h0, 0, 0, 0, 0));
    step("save_old_wim",      1, 0, 0, 0, 0, 32'h0,        1, 8'h01, 0, 4'h0, mk(4'h8, 3'd0, 1, 0, 1, 8'h01, 4'h0, 0, 0, 0, 0));
    step("save_0_to_7",       1, 0, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h8, 3'd7, 1, 0, 1, 8'h01, 4'h0, 0, 0, 0, 0));
    step("restore_underflow", 0, 1, 0, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h8, 3'd7, 1, 0, 1, 8'h01, 4'h0, 0, 1, 0, 0));
    step("trap_from_7",       0, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h8, 3'd6, 1, 1, 0, 8'h01, 4'h0, 0, 0, 0, 0));
    step("trap_et0_error",    0, 0, 1, 0, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h8, 3'd6, 1, 1, 0, 8'h01, 4'h0, 0, 0, 0, 1));
    step("error_sticky",      0, 0, 0, 0, 0, 32'h0,        1, 8'h80, 0, 4'h0, mk(4'h8, 3'd6, 1, 1, 0, 8'h80, 4'h0, 0, 0, 0, 1));
    step("rett_underflow",    0, 0, 0, 1, 0, 32'h0,        0, 8'h00, 0, 4'h0, mk(4'h8, 3'd6, 1, 1, 0, 8'h80, 4'h0, 0, 1, 0, 1));

    bus.save = 1'b1;
    bus.cc_we = 1'b1;
    bus.cc_in = 4'hF;
    Clr = 1'b1;
    #1;
    push("clr_mid_op", mk(4'h0, 3'd0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0));
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    Clr = 1'b0;
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
